// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter and its
// round-robin picker.
package dmem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NREQ     = 2;
  localparam int DEF_AW       = 32;
  localparam int DEF_DW       = 32;
  localparam int DEF_LOCK_MAX = 15;

  // Pointer/index width for n requesters, never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo N.
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int N  = DEF_NREQ,
  parameter int PW = ptr_w(DEF_NREQ)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan from ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!any && req[c]) begin
        grant[c] = 1'b1;
        idx      = PW'(c);
        any      = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port dmem between NREQ requesters,
// with a bounded lock for atomic sequences and a registered response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int PW = ptr_w(NREQ);
  localparam int HW = $clog2(LOCK_MAX + 1);

  arb_state_e      state_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   owner_r;
  logic [HW-1:0]   hold_cnt_r;
  logic [NREQ-1:0] rsp_valid_r;
  logic [DW-1:0]   rsp_rdata_r;

  logic [NREQ-1:0] eligible_s;
  logic [NREQ-1:0] grant_s;
  logic [PW-1:0]   pick_ptr_s;
  logic [PW-1:0]   win_idx_s;
  logic [PW-1:0]   win_next_s;
  logic [PW-1:0]   owner_next_s;
  logic            any_s;
  logic            win_lock_s;

  // Nothing is eligible during reset; while locked only the owner may compete.
  always_comb begin
    eligible_s = '0;
    pick_ptr_s = ptr_r;
    if (!reset) begin
      eligible_s = '0;
    end else if (state_r == LOCKED) begin
      eligible_s[owner_r] = req_valid[owner_r];
      pick_ptr_s          = owner_r;
    end else begin
      eligible_s = req_valid;
    end
  end

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req   (eligible_s),
    .ptr   (pick_ptr_s),
    .grant (grant_s),
    .idx   (win_idx_s),
    .any   (any_s)
  );

  assign win_next_s   = (int'(win_idx_s) == NREQ - 1) ? '0 : win_idx_s + PW'(1);
  assign owner_next_s = (int'(owner_r) == NREQ - 1) ? '0 : owner_r + PW'(1);

  // Memory port mux driven by the winner, zeroed when nobody wins.
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    win_lock_s = 1'b0;
    if (any_s) begin
      mem_we     = req_we[win_idx_s];
      mem_addr   = req_addr[int'(win_idx_s)*AW +: AW];
      mem_wdata  = req_wdata[int'(win_idx_s)*DW +: DW];
      win_lock_s = req_lock[win_idx_s];
    end else begin
      win_lock_s = 1'b0;
    end
  end

  // Arbitration FSM, lock hold counter and one-cycle response register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ARB;
      ptr_r       <= '0;
      owner_r     <= '0;
      hold_cnt_r  <= '0;
      rsp_valid_r <= '0;
      rsp_rdata_r <= '0;
    end else begin
      rsp_valid_r <= grant_s;
      if (any_s && !mem_we) begin
        rsp_rdata_r <= mem_rdata;
      end else begin
        rsp_rdata_r <= rsp_rdata_r;
      end

      case (state_r)
        ARB: begin
          if (any_s) begin
            ptr_r <= win_next_s;
            if (win_lock_s) begin
              state_r    <= LOCKED;
              owner_r    <= win_idx_s;
              hold_cnt_r <= '0;
            end else begin
              state_r <= ARB;
            end
          end else begin
            state_r <= ARB;
          end
        end
        LOCKED: begin
          if (any_s) begin
            if (win_lock_s) begin
              hold_cnt_r <= '0;
            end else begin
              state_r <= ARB;
              ptr_r   <= owner_next_s;
            end
          end else if (int'(hold_cnt_r) + 1 >= LOCK_MAX) begin
            // Idle budget spent: counter saturates at LOCK_MAX, grant released.
            hold_cnt_r <= HW'(LOCK_MAX);
            state_r    <= ARB;
            ptr_r      <= owner_next_s;
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
        end
        default: begin
          state_r <= ARB;
        end
      endcase
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small dmem model
// (combinational read, write on the accepting edge).
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [1:0]  req_lock;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  int checks = 0;
  int passed = 0;

  dmem_arbiter #(.NREQ(2), .AW(32), .DW(32), .LOCK_MAX(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_lock  = 2'b00;
    req_addr  = 64'h0;
    req_wdata = 64'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_reqs();
    req_valid = 2'b11;
    req_we    = 2'b11;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) $display("FAIL rst_ready got %b exp 00", req_ready); else passed++;
    checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %b exp 0", mem_we); else passed++;
    checks++; if (rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid got %b exp 00", rsp_valid); else passed++;
    checks++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); else passed++;
    step();
    clear_reqs();
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    req_valid = 2'b01;
    req_addr[31:0] = 32'h10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) $display("FAIL rd_ready got %b exp 01", req_ready); else passed++;
    checks++; if (mem_addr !== 32'h10) $display("FAIL rd_addr got %h exp 10", mem_addr); else passed++;
    checks++; if (mem_we !== 1'b0) $display("FAIL rd_we got %b exp 0", mem_we); else passed++;
    step();
    clear_reqs();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) $display("FAIL rd_rsp_valid got %b exp 01", rsp_valid); else passed++;
    checks++; if (rsp_rdata !== 32'hCAFE0001) $display("FAIL rd_rsp_rdata got %h exp cafe0001", rsp_rdata); else passed++;
    step();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) $display("FAIL rd_rsp_clear got %b exp 00", rsp_valid); else passed++;
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_g;
    logic [1:0]  prev_g;
    logic [31:0] prev_d;
    reset = 1'b0;
    step();
    reset = 1'b1;
    req_valid = 2'b11;
    req_addr  = {32'h4, 32'h0};
    prev_g = 2'b00;
    prev_d = 32'h0;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++; if (req_ready !== exp_g) $display("FAIL alt_grant%0d got %b exp %b", i, req_ready, exp_g); else passed++;
      if (i > 0) begin
        checks++; if (rsp_valid !== prev_g) $display("FAIL alt_rsp%0d got %b exp %b", i, rsp_valid, prev_g); else passed++;
        checks++; if (rsp_rdata !== prev_d) $display("FAIL alt_data%0d got %h exp %h", i, rsp_rdata, prev_d); else passed++;
      end
      prev_g = exp_g;
      prev_d = (i % 2 == 0) ? 32'hA0A00000 : 32'hB4B40004;
      step();
    end
    clear_reqs();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10) $display("FAIL alt_last_rsp got %b exp 10", rsp_valid); else passed++;
    checks++; if (rsp_rdata !== 32'hB4B40004) $display("FAIL alt_last_data got %h exp b4b40004", rsp_rdata); else passed++;
    step();
  endtask

  task automatic test_lock_write_read();
    // Lone req0 read moves the pointer to requester 1.
    req_valid = 2'b01;
    req_addr[31:0] = 32'h0;
    step();
    req_valid = 2'b11;
    req_we    = 2'b10;
    req_lock  = 2'b10;
    req_addr[63:32]  = 32'h20;
    req_wdata[63:32] = 32'h12345678;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) $display("FAIL lk_wr_grant got %b exp 10", req_ready); else passed++;
    checks++; if (mem_we !== 1'b1) $display("FAIL lk_wr_we got %b exp 1", mem_we); else passed++;
    checks++; if (mem_wdata !== 32'h12345678) $display("FAIL lk_wr_data got %h exp 12345678", mem_wdata); else passed++;
    step();
    req_we   = 2'b00;
    req_lock = 2'b00;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) $display("FAIL lk_rd_grant got %b exp 10", req_ready); else passed++;
    checks++; if (rsp_valid !== 2'b10) $display("FAIL lk_wr_ack got %b exp 10", rsp_valid); else passed++;
    step();
    req_valid = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) $display("FAIL lk_req0_grant got %b exp 01", req_ready); else passed++;
    checks++; if (rsp_rdata !== 32'h12345678) $display("FAIL lk_rd_data got %h exp 12345678", rsp_rdata); else passed++;
    checks++; if (mem[8] !== 32'h12345678) $display("FAIL lk_mem got %h exp 12345678", mem[8]); else passed++;
    step();
    clear_reqs();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) $display("FAIL lk_req0_rsp got %b exp 01", rsp_valid); else passed++;
    step();
  endtask

  task automatic test_lock_timeout();
    int blocked_bad;
    blocked_bad = 0;
    req_valid = 2'b01;
    req_lock  = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) $display("FAIL to_lock_grant got %b exp 01", req_ready); else passed++;
    step();
    clear_reqs();
    req_valid = 2'b10;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        blocked_bad++;
        $display("FAIL to_blocked cycle %0d got %b exp 00", c, req_ready);
      end
      step();
    end
    checks++; if (blocked_bad !== 0) $display("FAIL to_blocked_total got %0d exp 0", blocked_bad); else passed++;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) $display("FAIL to_release got %b exp 10", req_ready); else passed++;
    step();
    clear_reqs();
    step();
  endtask

  task automatic test_reset_locked();
    req_valid = 2'b10;
    req_lock  = 2'b10;
    req_addr  = {32'h0, 32'h0};
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) $display("FAIL rl_lock_grant got %b exp 10", req_ready); else passed++;
    step();
    clear_reqs();
    checks++; if (rsp_valid !== 2'b10) $display("FAIL rl_pending got %b exp 10", rsp_valid); else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00) $display("FAIL rl_rsp_drop got %b exp 00", rsp_valid); else passed++;
    req_valid = 2'b10;
    req_we    = 2'b10;
    req_addr[63:32]  = 32'h30;
    req_wdata[63:32] = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) $display("FAIL rl_no_write got %b exp 0", mem_we); else passed++;
    step();
    checks++; if (mem[12] !== 32'h0) $display("FAIL rl_mem got %h exp 0", mem[12]); else passed++;
    reset = 1'b1;
    clear_reqs();
    req_valid = 2'b11;
    req_addr  = {32'h0, 32'h10};
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) $display("FAIL rl_both_grant got %b exp 01", req_ready); else passed++;
    step();
    req_valid = 2'b10;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) $display("FAIL rl_req1_grant got %b exp 10", req_ready); else passed++;
    step();
    clear_reqs();
    step();
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    clear_reqs();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_we !== 1'b0 || mem_addr !== 32'h0 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
        bad++;
        $display("FAIL idle cycle %0d we=%b addr=%h ready=%b rsp=%b exp 0/0/00/00",
                 c, mem_we, mem_addr, req_ready, rsp_valid);
      end
      step();
    end
    checks++; if (bad !== 0) $display("FAIL idle_total got %0d bad cycles exp 0", bad); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'hA0A00000;
    mem[1] = 32'hB4B40004;
    mem[4] = 32'hCAFE0001;
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_write_read();
    test_lock_timeout();
    test_reset_locked();
    test_idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between up to NREQ requesters: the CPU load/store port, a loader/debug master, and future DMA. Each cycle it grants at most one request using round-robin priority, drives the memory port combinationally from the winner, and returns a registered one-cycle response. A lock mechanism with a bounded hold counter supports atomic multi-cycle sequences. It sits between the requesters and dmem inside top.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- LOCK_MAX, 15, maximum idle cycles a locked owner may hold the grant without issuing a request

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- req_valid  input  NREQ  request valid, one bit per requester
- req_we  input  NREQ  1 = write, 0 = read
- req_lock  input  NREQ  keep grant after this transfer
- req_addr  input  NREQ*AW  addresses, requester i at bits [i*AW +: AW]
- req_wdata  input  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- req_ready  output  NREQ  one-hot or zero; request i accepted when req_valid[i] & req_ready[i]
- rsp_valid  output  NREQ  one-cycle pulse, one cycle after acceptance
- rsp_rdata  output  DW  read data; valid with rsp_valid on reads
- mem_we  output  1  to dmem write enable
- mem_addr  output  AW  to dmem address
- mem_wdata  output  DW  to dmem write data
- mem_rdata  input  DW  from dmem, combinational read of mem_addr

## Operation
- State: ARB or LOCKED, plus the priority pointer ptr (0..NREQ-1), owner index, and the hold counter hold_cnt.
- ARB: the winner is the first i with req_valid[i] set, searching ptr, ptr+1, … modulo NREQ. req_ready is asserted for the winner only. The memory port carries the winner's we/addr/wdata.
- No winner: req_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- On acceptance, ptr <= (winner+1) mod NREQ.
- If the accepted request has req_lock = 1: go to LOCKED, owner <= winner, hold_cnt <= 0.
- LOCKED: only the owner may be granted. Other requesters see req_ready = 0 and ptr does not advance.
- Owner accepted with lock = 1: stay in LOCKED, hold_cnt <= 0.
- Owner accepted with lock = 0: go to ARB, ptr <= (owner+1) mod NREQ.
- Owner has no valid request: hold_cnt increments. When hold_cnt reaches LOCK_MAX, go to ARB at the next edge (forced release) with ptr <= (owner+1) mod NREQ.
- Response: on the edge that accepts request i, rsp_valid[i] is set and clears on the next edge unless another acceptance occurs.
  - Read: rsp_rdata <= mem_rdata.
  - Write: rsp_rdata holds its previous value; the rsp_valid pulse serves as the write ack.
- Writes commit in dmem on the same edge as acceptance. A read issued in the cycle after a write to the same address returns the new data.
- Reset mid-operation: a LOCKED state or pending response is discarded. No write is issued while reset is low.

## Timing
- Arbitration is combinational: req_valid to req_ready and mem_* within the same cycle. No combinational path from mem_rdata to any output.
- Throughput: one transfer per cycle. Back-to-back transfers from the same requester are allowed when no other requester is valid, or while LOCKED.
- Latency: acceptance at edge N gives rsp_valid high during cycle N+1.
- Reset values: state = ARB, ptr = 0, owner = 0, hold_cnt = 0, rsp_valid = 0, rsp_rdata = 0. The combinational outputs follow the no-winner rule.
- hold_cnt width is $clog2(LOCK_MAX+1); it never wraps.
- Requesters must hold valid/we/addr/wdata/lock stable until accepted.

## Structure
- Package dmem_arb_pkg:
  - state encoding: ARB = 1'b0, LOCKED = 1'b1
  - default widths
  - ptr_w function ($clog2 of NREQ, minimum 1)
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: request vector, ptr.
  - Outputs: one-hot grant, index, any.
- dmem_arbiter contains the FSM, the counters, the response register and the mux.

## Test plan
- Reset, then req0 reads 0x10 holding 0xCAFE0001 → req_ready[0] same cycle; next cycle rsp_valid = 2'b01, rsp_rdata = 0xCAFE0001.
- Both valid every cycle, reads to 0x0/0x4, starting from reset → grants alternate 0, 1, 0, 1; no requester is granted twice in a row.
- req1 writes 0x20 = 0x12345678 with lock = 1, then reads 0x20 with lock = 0, while req0 stays valid → req1 is granted both cycles and the read returns 0x12345678; req0 is granted on the third cycle.
- req0 locks, then idles while req1 is valid, LOCK_MAX = 15 → req1 is blocked for 15 cycles and granted on the next cycle after forced release.
- Reset asserted while LOCKED with a response pending → rsp_valid = 0 and the FSM is in ARB immediately. After release, req1 is granted first only if req0 is not valid.
- No requests → mem_we = 0, mem_addr = 0, req_ready = 0, rsp_valid = 0 for 20 cycles.
